// File: rtl/player_pkg.sv
// Screen/sprite geometry shared with the position tracker, plus the drawer state type.
package player_pkg;

    localparam int unsigned SCREEN_WIDTH  = 640;
    localparam int unsigned SCREEN_HEIGHT = 480;
    localparam int unsigned PLAYER_WIDTH  = 32;
    localparam int unsigned PLAYER_HEIGHT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/player_sprite_drawer_rect_scanner.sv
// Row-major col/row walker over a W x H rectangle; reused for erase and draw.
module rect_scanner #(
    parameter int unsigned W = 32,
    parameter int unsigned H = 32
) (
    input  logic                 CLOCK_50,
    input  logic                 global_reset,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(W)-1:0] col,
    output logic [$clog2(H)-1:0] row,
    output logic                 last
);

    localparam int unsigned COL_W = $clog2(W);
    localparam int unsigned ROW_W = $clog2(H);

    // Counter update: col wraps at W-1 and carries into row.
    always_ff @(posedge CLOCK_50) begin
        if (global_reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_W'(W - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Final pixel of the rectangle.
    always_comb begin
        last = (row == ROW_W'(H - 1)) && (col == COL_W'(W - 1));
    end

endmodule

// File: rtl/player_sprite_drawer.sv
// Erases the sprite at its previous centre and redraws it at the sampled centre,
// one frame-buffer pixel write per accepted handshake.
module player_sprite_drawer
    import player_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = player_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = player_pkg::SCREEN_HEIGHT,
    parameter int unsigned PLAYER_WIDTH  = player_pkg::PLAYER_WIDTH,
    parameter int unsigned PLAYER_HEIGHT = player_pkg::PLAYER_HEIGHT
) (
    input  logic                             CLOCK_50,
    input  logic                             global_reset,
    input  logic                             start,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  in_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] in_y,
    input  logic                             px_ready,
    output logic                             px_write,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  px_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] px_y,
    output logic                             px_color,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned X_W   = $clog2(SCREEN_WIDTH);
    localparam int unsigned Y_W   = $clog2(SCREEN_HEIGHT);
    localparam int unsigned COL_W = $clog2(PLAYER_WIDTH);
    localparam int unsigned ROW_W = $clog2(PLAYER_HEIGHT);

    draw_state_t        state, state_next;
    logic [X_W-1:0]     old_x, new_x;
    logic [Y_W-1:0]     old_y, new_y;
    logic               drawn_valid;

    logic               scan_clear, scan_advance, load_new, commit;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               scan_last;

    rect_scanner #(
        .W (PLAYER_WIDTH),
        .H (PLAYER_HEIGHT)
    ) u_scanner (
        .CLOCK_50     (CLOCK_50),
        .global_reset (global_reset),
        .clear        (scan_clear),
        .advance      (scan_advance),
        .col          (col),
        .row          (row),
        .last         (scan_last)
    );

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (global_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Target latch and last-drawn position bookkeeping.
    always_ff @(posedge CLOCK_50) begin
        if (global_reset) begin
            new_x       <= '0;
            new_y       <= '0;
            old_x       <= '0;
            old_y       <= '0;
            drawn_valid <= 1'b0;
        end else begin
            if (load_new) begin
                new_x <= in_x;
                new_y <= in_y;
            end
            if (commit) begin
                old_x       <= new_x;
                old_y       <= new_y;
                drawn_valid <= 1'b1;
            end
        end
    end

    // Next-state, scanner control and Moore output decode.
    always_comb begin
        state_next   = state;
        scan_clear   = 1'b0;
        scan_advance = 1'b0;
        load_new     = 1'b0;
        commit       = 1'b0;
        px_write     = 1'b0;
        px_color     = 1'b0;
        px_x         = '0;
        px_y         = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load_new   = 1'b1;
                    scan_clear = 1'b1;
                    if (drawn_valid && (in_x == old_x) && (in_y == old_y)) begin
                        state_next = DONE;
                    end else if (drawn_valid) begin
                        state_next = ERASE;
                    end else begin
                        state_next = DRAW;
                    end
                end
            end
            ERASE: begin
                busy     = 1'b1;
                px_write = 1'b1;
                px_color = 1'b0;
                px_x     = old_x - X_W'(PLAYER_WIDTH / 2) + X_W'(col);
                px_y     = old_y - Y_W'(PLAYER_HEIGHT / 2) + Y_W'(row);
                if (px_ready) begin
                    if (scan_last) begin
                        scan_clear = 1'b1;
                        state_next = DRAW;
                    end else begin
                        scan_advance = 1'b1;
                    end
                end
            end
            DRAW: begin
                busy     = 1'b1;
                px_write = 1'b1;
                px_color = 1'b1;
                px_x     = new_x - X_W'(PLAYER_WIDTH / 2) + X_W'(col);
                px_y     = new_y - Y_W'(PLAYER_HEIGHT / 2) + Y_W'(row);
                if (px_ready) begin
                    if (scan_last) begin
                        scan_clear = 1'b1;
                        commit     = 1'b1;
                        state_next = DONE;
                    end else begin
                        scan_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_player_sprite_drawer.sv
// Self-checking bench: scoreboard of expected pixel writes built from the sprite geometry.
module tb_player_sprite_drawer;

    localparam int PW = 32;
    localparam int PH = 32;
    localparam int BUDGET = 12000;

    logic       CLOCK_50 = 1'b0;
    logic       global_reset;
    logic       start;
    logic [9:0] in_x;
    logic [8:0] in_y;
    logic       px_ready;
    logic       px_write;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       px_color;
    logic       busy;
    logic       done;

    player_sprite_drawer dut (
        .CLOCK_50     (CLOCK_50),
        .global_reset (global_reset),
        .start        (start),
        .in_x         (in_x),
        .in_y         (in_y),
        .px_ready     (px_ready),
        .px_write     (px_write),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_color     (px_color),
        .busy         (busy),
        .done         (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: where the sprite currently sits on screen.
    int   m_old_x, m_old_y;
    bit   m_valid = 1'b0;

    // Per-repaint observations.
    int   w_count, w_erase, w_draw;
    pix_t w_first, w_last, w_first_draw;
    int   done_pulses;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Every pixel of the repaint, in scan order, derived from the sprite rectangle.
    task automatic build_expected(input int x, input int y);
        pix_t p;
        exp_q.delete();
        if (m_valid && x == m_old_x && y == m_old_y) return;
        if (m_valid) begin
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    p.x = m_old_x - PW / 2 + c;
                    p.y = m_old_y - PH / 2 + r;
                    p.c = 0;
                    exp_q.push_back(p);
                end
        end
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) begin
                p.x = x - PW / 2 + c;
                p.y = y - PH / 2 + r;
                p.c = 1;
                exp_q.push_back(p);
            end
    endtask

    // One repaint request; ready_pct throttles px_ready, stall_at/stall_len force a
    // fixed stall at an absolute write index, noise pokes start/in_x while busy,
    // reset_at >= 0 asserts reset when that many writes have been accepted.
    task automatic repaint(input int x, input int y, input int ready_pct,
                           input int stall_at, input int stall_len,
                           input bit noise, input int reset_at);
        int   cyc, stalls, stall_left, nexp;
        bit   got_done, hold, stall_used;
        pix_t e, h;
        build_expected(x, y);
        nexp = exp_q.size();
        check("idle_busy", busy, 0);
        check("idle_write", px_write, 0);
        w_count = 0; w_erase = 0; w_draw = 0; done_pulses = 0;
        stalls = 0; stall_left = 0; stall_used = 0; hold = 0; got_done = 0;
        in_x = 10'(x); in_y = 9'(y); start = 1'b1;
        px_ready = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        cyc = 1;
        while (1) begin
            if (hold) begin
                check("hold_write", px_write, 1);
                check("hold_x", px_x, h.x);
                check("hold_y", px_y, h.y);
                check("hold_color", px_color, h.c);
            end
            hold = 0;
            if (done) begin
                got_done = 1;
                done_pulses++;
                check("done_cycle", cyc, nexp + stalls + 1);
                check("done_busy", busy, 1);
                check("done_left", exp_q.size(), 0);
                start = 1'b0;
                break;
            end
            check("busy", busy, 1);
            check("write_on", px_write, 1);
            if (reset_at >= 0 && w_count == reset_at) begin
                global_reset = 1'b1;
                @(negedge CLOCK_50);
                check("rst_write", px_write, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_x", px_x, 0);
                check("rst_y", px_y, 0);
                check("rst_color", px_color, 0);
                global_reset = 1'b0;
                m_valid = 1'b0;
                exp_q.delete();
                return;
            end
            if (stall_left > 0) begin
                px_ready = 1'b0;
                stall_left--;
            end else if (!stall_used && stall_len > 0 && w_count == stall_at) begin
                stall_used = 1;
                px_ready = 1'b0;
                stall_left = stall_len - 1;
            end else begin
                px_ready = ($urandom_range(99) < 32'(ready_pct));
            end
            if (px_ready && px_write) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("px_x", px_x, e.x);
                    check("px_y", px_y, e.y);
                    check("px_color", px_color, e.c);
                end
                h.x = px_x; h.y = px_y; h.c = px_color;
                if (w_count == 0) w_first = h;
                if (px_color && w_draw == 0) w_first_draw = h;
                w_last = h;
                w_count++;
                if (px_color) w_draw++; else w_erase++;
            end else begin
                stalls++;
                hold = 1;
                h.x = px_x; h.y = px_y; h.c = px_color;
            end
            if (noise) begin
                start = ($urandom_range(3) == 0);
                in_x  = 10'($urandom_range(623, 16));
            end
            @(negedge CLOCK_50);
            cyc++;
            if (cyc > BUDGET) break;
        end
        if (!got_done) begin
            check("done_timeout", 0, 1);
            return;
        end
        @(negedge CLOCK_50);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_write", px_write, 0);
        if (exp_q.size() == 0 || nexp == 0) begin
            m_old_x = x; m_old_y = y; m_valid = 1'b1;
        end
    endtask

    initial begin
        int rx, ry;
        global_reset = 1'b1; start = 1'b0; px_ready = 1'b0; in_x = '0; in_y = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_write", px_write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_color", px_color, 0);
        check("rst_x", px_x, 0);
        check("rst_y", px_y, 0);
        global_reset = 1'b0;
        @(negedge CLOCK_50);

        // First draw: no erase, fixed corners.
        repaint(320, 454, 100, -1, 0, 0, -1);
        check("first_count", w_count, 1024);
        check("first_erase", w_erase, 0);
        check("first_x0", w_first.x, 304);
        check("first_y0", w_first.y, 438);
        check("first_xl", w_last.x, 335);
        check("first_yl", w_last.y, 469);

        // Move by one pixel: erase then draw.
        repaint(321, 454, 100, -1, 0, 0, -1);
        check("move_erase", w_erase, 1024);
        check("move_draw", w_draw, 1024);
        check("move_x0", w_first.x, 304);
        check("move_y0", w_first.y, 438);
        check("move_dx0", w_first_draw.x, 305);
        check("move_xl", w_last.x, 336);
        check("move_yl", w_last.y, 469);
        check("move_pulses", done_pulses, 1);

        // Same position: no writes, done right away.
        repaint(321, 454, 100, -1, 0, 0, -1);
        check("same_count", w_count, 0);

        // Five-cycle stall at draw pixel 10.
        repaint(325, 454, 100, 1024 + 10, 5, 0, -1);
        check("stall_draw", w_draw, 1024);

        // start/in_x noise while busy is ignored.
        repaint(300, 200, 100, -1, 0, 1, -1);
        check("noise_count", w_count, 2048);

        // Reset at erase pixel 100, then redraw without erase.
        repaint(340, 454, 100, -1, 0, 0, 100);
        @(negedge CLOCK_50);
        repaint(330, 454, 100, -1, 0, 0, -1);
        check("post_rst_erase", w_erase, 0);
        check("post_rst_x0", w_first.x, 314);
        check("post_rst_y0", w_first.y, 438);

        // Randomized repaints with random backpressure.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(3) == 0) begin
                rx = m_old_x; ry = m_old_y;
            end else begin
                rx = int'($urandom_range(623, 16));
                ry = int'($urandom_range(463, 16));
            end
            repaint(rx, ry, 60 + int'($urandom_range(40)), -1, 0, ($urandom_range(1) == 1), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_sprite_drawer.md
# player_sprite_drawer

Downstream consumer of the player position tracker: watches the player's centre coordinate and repaints the player sprite into the 640x480, 1-bit VGA frame buffer. On each `start` request it erases the rectangle at the previously drawn position, then draws a solid rectangle at the newly sampled position. It emits one pixel write per accepted handshake to the frame-buffer write arbiter.

## Interface
- `SCREEN_WIDTH`, default 640: frame-buffer width in pixels.
- `SCREEN_HEIGHT`, default 480: frame-buffer height in pixels.
- `PLAYER_WIDTH`, default 32: sprite width in pixels; must be even.
- `PLAYER_HEIGHT`, default 32: sprite height in pixels; must be even.

- `CLOCK_50`  in  1  sole clock; all state updates on its rising edge.
- `global_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  repaint request; sampled only in IDLE.
- `in_x`  in  10  player centre x, from the position tracker's `out_x`.
- `in_y`  in  9  player centre y, from the position tracker's `out_y`.
- `px_ready`  in  1  arbiter can accept the current pixel.
- `px_write`  out  1  pixel valid.
- `px_x`  out  10  pixel x.
- `px_y`  out  9  pixel y.
- `px_color`  out  1  0 = background (erase), 1 = player (draw).
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse when a repaint completes.

## Operation
- State machine with four states: IDLE, ERASE, DRAW, DONE.
- Internal registers:
  - `old_x`/`old_y`: last drawn centre.
  - `drawn_valid`: cleared by reset.
  - `new_x`/`new_y`: latched target.
  - `col` (0..W-1) and `row` (0..H-1).
- IDLE with `start`=1:
  - Latch `new_x`/`new_y` from `in_x`/`in_y`.
  - Clear `col`/`row`.
  - If `drawn_valid` and new == old: go to DONE, with no pixel writes.
  - Else if `drawn_valid`: go to ERASE.
  - Else: go to DRAW.
- ERASE:
  - `px_write`=1, `px_color`=0.
  - `px_x` = `old_x` - W/2 + `col`; `px_y` = `old_y` - H/2 + `row`.
- DRAW:
  - Same scan over `new_x`/`new_y`, with `px_color`=1.
- Scan order: row-major; `col` increments on every accepted handshake (`px_write` && `px_ready`). When `col` reaches W-1, `col` returns to 0 and `row` increments.
- End of each phase:
  - Accepting the pixel at `row`=H-1, `col`=W-1 ends the phase.
  - ERASE then moves to DRAW with counters cleared.
  - DRAW then moves to DONE and loads `old` from `new`, setting `drawn_valid`=1.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Backpressure: while `px_ready`=0, `px_x`, `px_y`, `px_color` and `px_write` hold stable and the counters do not advance.
- `start` while not in IDLE is ignored; it is not queued.
- `in_x`/`in_y` changing mid-repaint has no effect; only the latched value is used.
- Arithmetic: unsigned, at port widths (10-bit x, 9-bit y). The upstream tracker keeps the centre within padding, so no clipping or underflow handling is required.
- Each non-trivial repaint issues exactly W*H erase writes (when `drawn_valid`) plus W*H draw writes.

## Timing
- Reset values:
  - State IDLE.
  - `px_write`, `busy`, `done`, `px_color` all 0.
  - `px_x`, `px_y` 0.
  - `drawn_valid` 0; counters 0.
- Outputs are Moore: decoded from registered state and counters only. There is no combinational path from `px_ready` or `start` to any output.
- Start accepted at edge k: the first pixel is valid in cycle k+1.
- With `px_ready` held at 1: one pixel per cycle.
  - First draw: 1024 write cycles, then DONE. `done` is high in the cycle at offset 1025 after edge k.
  - Erase plus draw: 2048 write cycles, then `done`.
- Unchanged position: `done` is high in the cycle after edge k.
- Reset mid-operation:
  - The next cycle is IDLE with all outputs at reset values.
  - `drawn_valid` is cleared, so the next repaint draws without erasing.

## Structure
- Shared package `player_pkg`:
  - Screen and player dimension constants, shared with the position tracker.
  - `draw_state_t` enum (IDLE, ERASE, DRAW, DONE).
- Sub-module `rect_scanner`:
  - Row/col counters with `clear` and `advance` inputs.
  - `last` flag, high at (H-1, W-1).
  - Instantiated once and reused for both phases.

## Test plan
- Reset, then `start` with (320,454), `px_ready`=1:
  - 1024 writes, all with `px_color`=1.
  - First pixel (304,438); pixel 33 is (304,439); last pixel (335,469).
  - `done` in the cycle at offset 1025 after the `start` edge; no erase writes.
- Then `start` with (321,454):
  - 1024 erase writes from (304,438) to (335,469).
  - Then 1024 draw writes from (305,438) to (336,469).
  - `busy` continuously high; a single `done`.
- Then `start` with (321,454) again:
  - Zero writes; `done` in the cycle after the `start` edge; `busy` high only that cycle.
- Drop `px_ready` for 5 cycles at draw pixel 10:
  - `px_x`/`px_y`/`px_color` held for those 5 cycles.
  - Total draw count still 1024; `done` delayed by exactly 5 cycles.
- Pulse `start` with a different `in_x` while busy:
  - Ignored; the repaint completes at the originally latched coordinates.
- Assert `global_reset` at erase pixel 100:
  - Next cycle: `px_write`=0, `busy`=0.
  - A following `start` with (330,454) draws directly with no erase: first pixel (314,438).
